md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencer for the multiply/divide resource in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and latches operands.
- Runs a fixed-latency busy countdown, then commits results to HI/LO.
- Generates the D-stage stall request for any instruction that touches HI/LO while the unit is occupied or being started.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is a HI/LO-writing op; qualifies op
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub
- rs_val  input  32  forwarded rs operand (E stage)
- rt_val  input  32  forwarded rt operand (E stage)
- d_md_use  input  1  D-stage instruction reads or writes HI/LO (mfhi/mflo/mult/.../mtlo)
- busy  output  1  countdown in progress
- busy_cnt  output  4  remaining busy cycles
- hi  output  32  HI register
- lo  output  32  LO register
- stall  output  1  D-stage stall request
- err_overlap  output  1  one-cycle pulse: start seen while busy (op ignored)

Behaviour:
- Reset (synchronous, any state, including mid-operation): hi=0, lo=0, busy_cnt=0, busy=0, err_overlap=0. Latched operands and any pending result are discarded.
- States: IDLE (busy_cnt==0), RUN (busy_cnt!=0). busy = (busy_cnt!=0), combinational from the counter.
- IDLE, start, op in {0,1,2,3}:
  - At edge T, latch rs_val/rt_val/op and load busy_cnt = MULT_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles after T.
- RUN: busy_cnt decrements every edge. On the edge where busy_cnt==1, busy_cnt goes to 0 and hi/lo take the result on that same edge. New HI/LO are visible in the first cycle busy is low.
- Arithmetic:
  - mult: signed 32x32 -> 64; {hi,lo} = product.
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
  - 0x80000000 / -1 (div): lo=0x80000000, hi=0.
  - Divisor 0: full DIV_CYCLES busy, hi/lo unchanged at commit.
- mthi/mtlo (op 4/5) in IDLE: at edge T, hi (resp. lo) <= rs_val. busy stays 0; latency 1.
- Start while RUN (any op): ignored. err_overlap pulses high for the cycle after that edge. Counter and pending result are unaffected.
- op 6/7 when MD_MADD_EN is not defined: treated as no-op (no busy, no write).
- stall = d_md_use && (busy || start), combinational.
  - Covers the start-in-E / HI/LO-user-in-D case.
  - Holds while busy_cnt>0, drops in the cycle busy falls.
- Simultaneous start and final commit cannot occur: stall prevents it. If forced, commit wins and err_overlap pulses.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: op 6 (madd) and op 7 (msub) become valid MULT_CYCLES operations.
  - Signed product is added to (madd) or subtracted from (msub) the {hi,lo} value present at commit time, modulo 2^64.
- Undefined: op 6/7 are no-ops as above, and no accumulate adder is synthesised.

Test Plan:
1. Reset, then start op=0, rs=0xFFFFFFFE (-2), rt=3 -> busy=1 for exactly 5 cycles, busy_cnt 5,4,3,2,1; next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. op=3 (divu) rs=7, rt=2 -> busy 10 cycles, then lo=3, hi=1; op=2 rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divisor 0 -> hi/lo unchanged after 10 cycles.
3. Start mult with d_md_use=1 held -> stall=1 in start cycle and all 5 busy cycles, 0 in the cycle hi/lo updates; mthi rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never asserts.
4. Start div, then start mult 3 cycles later -> err_overlap single pulse, busy_cnt continues 7,6,...; final hi/lo equal the div result.
5. Start divu, assert reset at busy_cnt=4 -> next cycle hi=lo=0, busy=0, stall depends only on d_md_use&&start; no late commit appears in the following 10 cycles.
6. (MD_MADD_EN) hi/lo=0:1, madd rs=2, rt=3 -> after 5 cycles hi=0, lo=7; msub rs=1, rt=8 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/md_sched.sv
// Multiply/divide sequencer for the 5-stage MIPS pipeline: fixed-latency countdown, HI/LO commit and D-stage stall.
// Optional macro MD_MADD_EN enables madd/msub (op 6/7) with a 64-bit accumulate at commit.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_md_use,
   output logic        busy,
   output logic [3:0]  busy_cnt,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall,
   output logic        err_overlap
);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MADD  = 3'd6,
      OP_MSUB  = 3'd7
   } md_op_e;

   typedef enum logic {IDLE, RUN} state_e;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_e      state;
   md_op_e      op_q;
   logic [31:0] a_q, b_q;

   logic [3:0]  cnt_d;
   logic [31:0] hi_d, lo_d;
   logic        err_d;
   logic        capture;

   assign state = (busy_cnt != 4'd0) ? RUN : IDLE;
   assign busy  = (state == RUN);
   assign stall = d_md_use && (busy || start);

   // Multiply: extend to 64 bits so one unsigned multiplier serves both signednesses.
   logic        mul_signed;
   logic [63:0] ext_a, ext_b, prod;

   assign mul_signed = (op_q != OP_MULTU);
   assign ext_a      = {{32{mul_signed & a_q[31]}}, a_q};
   assign ext_b      = {{32{mul_signed & b_q[31]}}, b_q};
   assign prod       = ext_a * ext_b;

   // Divide on magnitudes, then restore signs; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
   logic        div_signed, neg_a, neg_b;
   logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quo, rem;

   assign div_signed = (op_q == OP_DIV);
   assign neg_a      = div_signed & a_q[31];
   assign neg_b      = div_signed & b_q[31];
   assign mag_a      = neg_a ? (32'd0 - a_q) : a_q;
   assign mag_b      = neg_b ? (32'd0 - b_q) : b_q;
   assign divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign q_mag      = mag_a / divisor;
   assign r_mag      = mag_a % divisor;
   assign quo        = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
   assign rem        = neg_a ? (32'd0 - r_mag) : r_mag;

`ifdef MD_MADD_EN
   logic [63:0] acc;
   assign acc = (op_q == OP_MSUB) ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cnt_d   = busy_cnt;
      hi_d    = hi;
      lo_d    = lo;
      err_d   = 1'b0;
      capture = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (md_op_e'(op))
                  OP_MULT, OP_MULTU: begin capture = 1'b1; cnt_d = MULT_N; end
                  OP_DIV, OP_DIVU:   begin capture = 1'b1; cnt_d = DIV_N;  end
                  OP_MTHI:           hi_d = rs_val;
                  OP_MTLO:           lo_d = rs_val;
`ifdef MD_MADD_EN
                  OP_MADD, OP_MSUB:  begin capture = 1'b1; cnt_d = MULT_N; end
`endif
                  default: ;
               endcase
            end
         end
         RUN: begin
            // A start while running is dropped; only the error pulse records it.
            cnt_d = busy_cnt - 4'd1;
            err_d = start;
            if (busy_cnt == 4'd1) begin
               case (op_q)
                  OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                  OP_DIV, OP_DIVU:   if (b_q != 32'd0) {hi_d, lo_d} = {rem, quo};
`ifdef MD_MADD_EN
                  OP_MADD, OP_MSUB:  {hi_d, lo_d} = acc;
`endif
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_cnt    <= 4'd0;
         hi          <= 32'd0;
         lo          <= 32'd0;
         err_overlap <= 1'b0;
      end else begin
         busy_cnt    <= cnt_d;
         hi          <= hi_d;
         lo          <= lo_d;
         err_overlap <= err_d;
      end
   end

   // NOTE: operand latches have no reset; a cleared counter guarantees stale operands are never committed.
   always_ff @(posedge clk) begin
      if (capture) begin
         op_q <= md_op_e'(op);
         a_q  <= rs_val;
         b_q  <= rt_val;
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed plan steps plus randomized ops against an arithmetic reference model.
module tb_md_sched;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] rs = 32'd0;
   logic [31:0] rt = 32'd0;
   logic        d_md_use = 1'b0;
   logic        busy;
   logic [3:0]  busy_cnt;
   logic [31:0] hi, lo;
   logic        stall;
   logic        err_overlap;

   int checks = 0;
   int failures = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op_i), .rs_val(rs), .rt_val(rt),
      .d_md_use(d_md_use), .busy(busy), .busy_cnt(busy_cnt), .hi(hi), .lo(lo),
      .stall(stall), .err_overlap(err_overlap)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit madd_en();
`ifdef MD_MADD_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int op_cycles(input logic [2:0] o);
      case (o)
         3'd0, 3'd1: return MULT_N;
         3'd2, 3'd3: return DIV_N;
         3'd6, 3'd7: return madd_en() ? MULT_N : 0;
         default:    return 0;
      endcase
   endfunction

   // Reference: {hi,lo} after the op completes, from MIPS arithmetic rules on 64-bit integers.
   function automatic logic [63:0] md_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hl);
      longint sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [63:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         3'd0: return sa * sb;
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 32'd0) return hl;
            sq = sa / sb;
            sr = sa % sb;
            q = sq;
            r = sr;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 32'd0) return hl;
            q = ua / ub;
            r = ua % ub;
            return {r[31:0], q[31:0]};
         end
         3'd4: return {a, hl[31:0]};
         3'd5: return {hl[63:32], a};
         3'd6: return madd_en() ? hl + 64'(sa * sb) : hl;
         default: return madd_en() ? hl - 64'(sa * sb) : hl;
      endcase
   endfunction

   // Issue one op from IDLE and follow it to completion, checking every cycle.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic use_d);
      int n;
      logic [63:0] exp_hl;
      n = op_cycles(o);
      exp_hl = md_model(o, a, b, {m_hi, m_lo});
      start = 1'b1; op_i = o; rs = a; rt = b; d_md_use = use_d;
      #1;
      check("stall_at_start", stall, use_d);
      tick();
      start = 1'b0;
      #1;
      for (int i = n; i >= 1; i--) begin
         check("busy_run", busy, 1'b1);
         check("busy_cnt_run", busy_cnt, i);
         check("stall_run", stall, use_d);
         tick();
      end
      {m_hi, m_lo} = exp_hl;
      check("busy_done", busy, 1'b0);
      check("busy_cnt_done", busy_cnt, 0);
      check("stall_done", stall, 1'b0);
      check("err_done", err_overlap, 1'b0);
      check("hi_done", hi, m_hi);
      check("lo_done", lo, m_lo);
      d_md_use = 1'b0;
   endtask

   initial begin
      logic [63:0] exp_hl;
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;

      tick(); tick();
      reset = 1'b0;
      #1;
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_busy", busy, 1'b0);
      check("reset_cnt", busy_cnt, 4'd0);
      check("reset_err", err_overlap, 1'b0);

      // Plan 1: mult -2 * 3.
      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
      check("p1_hi", hi, 32'hFFFF_FFFF);
      check("p1_lo", lo, 32'hFFFF_FFFA);

      // Plan 2: divu, signed div, divide by zero.
      run_op(3'd3, 32'd7, 32'd2, 1'b0);
      check("p2_divu_lo", lo, 32'd3);
      check("p2_divu_hi", hi, 32'd1);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("p2_div_lo", lo, 32'hFFFF_FFFD);
      check("p2_div_hi", hi, 32'hFFFF_FFFF);
      run_op(3'd2, 32'd1234, 32'd0, 1'b0);
      check("p2_div0_lo", lo, 32'hFFFF_FFFD);
      check("p2_div0_hi", hi, 32'hFFFF_FFFF);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'd0);

      // Plan 3: stall across a mult, then mthi in IDLE.
      run_op(3'd0, 32'd9, 32'd9, 1'b1);
      run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
      check("p3_mthi", hi, 32'h1234_5678);

      // Plan 4: overlapping start during a div.
      exp_hl = md_model(3'd2, 32'd100, 32'd7, {m_hi, m_lo});
      start = 1'b1; op_i = 3'd2; rs = 32'd100; rt = 32'd7;
      tick();
      start = 1'b0;
      #1;
      check("p4_cnt10", busy_cnt, 4'd10);
      tick();
      tick();
      check("p4_cnt8", busy_cnt, 4'd8);
      start = 1'b1; op_i = 3'd0; rs = 32'd5; rt = 32'd5;
      tick();
      start = 1'b0;
      #1;
      check("p4_err_pulse", err_overlap, 1'b1);
      check("p4_cnt7", busy_cnt, 4'd7);
      tick();
      for (int i = 6; i >= 1; i--) begin
         if (i == 6) check("p4_err_single", err_overlap, 1'b0);
         check("p4_cnt", busy_cnt, i);
         tick();
      end
      {m_hi, m_lo} = exp_hl;
      check("p4_busy_done", busy, 1'b0);
      check("p4_hi", hi, 32'd2);
      check("p4_lo", lo, 32'd14);

      // Plan 5: reset in mid-operation.
      start = 1'b1; op_i = 3'd3; rs = 32'd50; rt = 32'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("p5_cnt4", busy_cnt, 4'd4);
      reset = 1'b1; d_md_use = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      m_hi = 32'd0; m_lo = 32'd0;
      check("p5_hi", hi, 32'd0);
      check("p5_lo", lo, 32'd0);
      check("p5_busy", busy, 1'b0);
      check("p5_cnt", busy_cnt, 4'd0);
      check("p5_stall_idle", stall, 1'b0);
      start = 1'b1; op_i = 3'd0;
      #1;
      check("p5_stall_start", stall, 1'b1);
      start = 1'b0; d_md_use = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("p5_no_late_busy", busy, 1'b0);
         check("p5_no_late_hi", hi, 32'd0);
         check("p5_no_late_lo", lo, 32'd0);
      end

      // Plan 6: accumulate ops (no-ops in the default build, tracked by the model either way).
      run_op(3'd4, 32'd0, 32'd0, 1'b0);
      run_op(3'd5, 32'd1, 32'd0, 1'b0);
      run_op(3'd6, 32'd2, 32'd3, 1'b0);
      check("p6_madd_hi", hi, madd_en() ? 32'd0 : 32'd0);
      check("p6_madd_lo", lo, madd_en() ? 32'd7 : 32'd1);
      run_op(3'd7, 32'd1, 32'd8, 1'b0);
      check("p6_msub_hi", hi, madd_en() ? 32'hFFFF_FFFF : 32'd0);
      check("p6_msub_lo", lo, madd_en() ? 32'hFFFF_FFFF : 32'd1);

      // Randomized ops against the model.
      for (int k = 0; k < 40; k++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = $urandom;
         case ($urandom_range(0, 3))
            0:       r_b = 32'($urandom_range(0, 2));
            1:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            default: r_b = $urandom;
         endcase
         run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
